// File: rtl/seg_display_ctrl.sv
// Binary-to-BCD display controller: converts a 32-bit write into eight BCD digits
// by double-dabble, with saturation at 99_999_999 and a one-deep pending write.
module seg_display_ctrl (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        wr_en_i,
  input  logic [31:0] wr_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        ovf_o,
  output logic [6:0]  io_hex0_o,
  output logic [6:0]  io_hex1_o,
  output logic [6:0]  io_hex2_o,
  output logic [6:0]  io_hex3_o,
  output logic [6:0]  io_hex4_o,
  output logic [6:0]  io_hex5_o,
  output logic [6:0]  io_hex6_o,
  output logic [6:0]  io_hex7_o
);

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  localparam logic [31:0] MAX_VAL = 32'd99_999_999;

  state_t      state;
  logic [63:0] sr;
  logic [63:0] sr_add;
  logic [63:0] sr_step;
  logic [5:0]  cnt;
  logic        pend_vld;
  logic [31:0] pend_data;
  logic        conv_ovf;

  // {overflow, saturated value}
  function automatic logic [32:0] saturate(input logic [31:0] v);
    if (v > MAX_VAL) return {1'b1, MAX_VAL};
    else             return {1'b0, v};
  endfunction

  always_comb begin
    sr_add = sr;
    for (int unsigned i = 0; i < 8; i++) begin
      if (sr[32 + 4*i +: 4] >= 4'd5)
        sr_add[32 + 4*i +: 4] = sr[32 + 4*i +: 4] + 4'd3;
    end
    sr_step = sr_add << 1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      sr        <= '0;
      cnt       <= '0;
      pend_vld  <= 1'b0;
      pend_data <= '0;
      conv_ovf  <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      ovf_o     <= 1'b0;
      io_hex0_o <= '0;
      io_hex1_o <= '0;
      io_hex2_o <= '0;
      io_hex3_o <= '0;
      io_hex4_o <= '0;
      io_hex5_o <= '0;
      io_hex6_o <= '0;
      io_hex7_o <= '0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (wr_en_i) begin
            sr       <= {32'd0, saturate(wr_data_i)[31:0]};
            conv_ovf <= saturate(wr_data_i)[32];
            cnt      <= '0;
            busy_o   <= 1'b1;
            state    <= SHIFT;
          end
        end
        SHIFT: begin
          sr  <= sr_step;
          cnt <= cnt + 6'd1;
          if (wr_en_i) begin
            pend_vld  <= 1'b1;
            pend_data <= wr_data_i;
          end
          if (cnt == 6'd31) state <= UPDATE;
        end
        UPDATE: begin
          io_hex0_o <= {3'b000, sr[35:32]};
          io_hex1_o <= {3'b000, sr[39:36]};
          io_hex2_o <= {3'b000, sr[43:40]};
          io_hex3_o <= {3'b000, sr[47:44]};
          io_hex4_o <= {3'b000, sr[51:48]};
          io_hex5_o <= {3'b000, sr[55:52]};
          io_hex6_o <= {3'b000, sr[59:56]};
          io_hex7_o <= {3'b000, sr[63:60]};
          ovf_o     <= conv_ovf;
          done_o    <= 1'b1;
          cnt       <= '0;
          // Same-cycle write beats the pending one; either way pending is consumed
          if (wr_en_i) begin
            sr       <= {32'd0, saturate(wr_data_i)[31:0]};
            conv_ovf <= saturate(wr_data_i)[32];
            pend_vld <= 1'b0;
            state    <= SHIFT;
          end else if (pend_vld) begin
            sr       <= {32'd0, saturate(pend_data)[31:0]};
            conv_ovf <= saturate(pend_data)[32];
            pend_vld <= 1'b0;
            state    <= SHIFT;
          end else begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/seg_display_ctrl.md
SEG_DISPLAY_CTRL -- requirements
Module: seg_display_ctrl

Interface
REQ-001 SHALL have ports exactly as follows, clock and reset first:
- clk_i  input  1  system clock; single clock domain.
- rst_i  input  1  reset; synchronous, active-high.
- wr_en_i  input  1  one-cycle write strobe from the I/O store path.
- wr_data_i  input  32  unsigned binary value to display.
- busy_o  output  1  conversion in progress.
- done_o  output  1  one-cycle pulse when the digit outputs update.
- ovf_o  output  1  displayed value was saturated.
- io_hex0_o .. io_hex7_o  output  7 each  BCD digit codes for the 7-segment decoder:
  - bits[3:0] hold the digit, 0-9;
  - bits[6:4] are always 0;
  - hex0 is the least significant digit.

Function
REQ-002 SHALL implement the state machine IDLE -> SHIFT -> UPDATE -> (IDLE or SHIFT).
REQ-003 IDLE: on wr_en_i=1, SHALL capture wr_data_i and enter SHIFT with the iteration counter cleared.
REQ-004 Saturation at capture:
- A value > 99_999_999 SHALL be replaced by 99_999_999.
- The per-conversion overflow flag SHALL be set; otherwise it SHALL be cleared.
REQ-005 SHIFT SHALL perform one double-dabble iteration per cycle:
- add 3 to every 4-bit BCD digit >= 5;
- then shift the {BCD[31:0], binary[31:0]} register left by one.
- This SHALL repeat for exactly 32 iterations.
- The counter SHALL be 6 bits wide.
REQ-006 After the 32nd iteration, the machine SHALL enter UPDATE.
REQ-007 UPDATE SHALL load all eight digit outputs and ovf_o atomically in one edge and assert done_o for exactly the following cycle.
REQ-008 Latency: if a write is accepted at edge t, the digit outputs and done_o SHALL become valid after edge t+33.
REQ-009 busy_o SHALL be 1 in SHIFT and UPDATE and 0 in IDLE.
REQ-010 Digit outputs and ovf_o SHALL hold their values between updates; no intermediate conversion value SHALL ever appear on them.
REQ-011 A wr_en_i during SHIFT SHALL be stored in a one-deep pending register:
- the pending-valid flag SHALL be set;
- a later write SHALL overwrite an earlier one (last write wins).
REQ-012 At the UPDATE edge, the next source SHALL be selected in this priority order:
- wr_en_i data in that same cycle (starts SHIFT);
- otherwise the pending register (starts SHIFT, clears pending-valid);
- otherwise the machine returns to IDLE.
REQ-013 Any write started from UPDATE SHALL be saturated per REQ-004.
REQ-014 wr_en_i in IDLE with pending-valid=0 SHALL NOT be delayed; pending-valid is always 0 in IDLE.
REQ-015 Every BCD digit produced SHALL be within 0-9.
REQ-016 Value 0 SHALL produce 0 on all eight outputs; no leading-zero blanking is applied.

Reset
REQ-017 On rst_i=1 at a clock edge, the block SHALL force, regardless of state:
- state = IDLE;
- pending-valid = 0;
- counter = 0;
- busy_o = 0, done_o = 0, ovf_o = 0;
- all io_hexN_o = 7'h00.
REQ-018 A reset during SHIFT or UPDATE SHALL abort the conversion without updating outputs and SHALL discard the pending value.
REQ-019 wr_en_i asserted in the same cycle as rst_i SHALL be ignored.

Verification
REQ-020 Reset: hold rst_i=1 for 2 cycles -> all io_hexN_o=0, busy_o=0, done_o=0, ovf_o=0.
REQ-021 Basic write: wr_data_i=12_345_678 at edge t -> after edge t+33, hex7..hex0=1,2,3,4,5,6,7,8, ovf_o=0, done_o=1 for one cycle; busy_o=0 after edge t+34.
REQ-022 Overflow: wr_data_i=32'hFFFF_FFFF -> all digits 9, ovf_o=1. Then write 42 -> hex1=4, hex0=2, all other digits 0, ovf_o=0.
REQ-023 Queued writes: write 5 at t, 7 at t+3, 9 at t+10 ->
- first update shows 5;
- a second conversion starts immediately and shows 9;
- 7 is never displayed;
- exactly two done_o pulses occur.
REQ-024 Write in UPDATE: a write in the UPDATE cycle while pending holds another value -> the UPDATE-cycle data is converted next, pending is cleared, and no third conversion occurs.
REQ-025 Reset mid-conversion: write 99 then assert rst_i at t+15 -> outputs remain 0, no done_o pulse; a write after reset of 99_999_999 -> all digits 9, ovf_o=0.
